// File: rtl/local_predictor_2lvl.sv
// local_predictor_2lvl: two-level local branch predictor (per-PC history table indexing a shared table of saturating counters).
// Optional feature: define LP_BYPASS_EN to forward a same-cycle update into a same-cycle prediction.
module local_predictor_2lvl #(
    parameter int PC_BITS      = 32,
    parameter int LHT_IDX_BITS = 6,
    parameter int HIST_BITS    = 10,
    parameter int CTR_BITS     = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    output logic                 ready,
    input  logic                 pred_valid,
    input  logic [PC_BITS-1:0]   pred_pc,
    output logic                 pred_resp_valid,
    output logic                 pred_taken,
    output logic [HIST_BITS-1:0] pred_hist,
    input  logic                 upd_valid,
    input  logic [PC_BITS-1:0]   upd_pc,
    input  logic                 upd_taken
);
    localparam int IDX_BITS = (LHT_IDX_BITS > HIST_BITS) ? LHT_IDX_BITS : HIST_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

    typedef enum logic {INIT, READY} state_t;

    state_t                r_state;
    logic [IDX_BITS-1:0]   r_idx;
    logic [HIST_BITS-1:0]  r_lht [2**LHT_IDX_BITS];
    logic [CTR_BITS-1:0]   r_pht [2**HIST_BITS];
    logic                  r_resp_valid;
    logic                  r_pred_taken;
    logic [HIST_BITS-1:0]  r_pred_hist;

    logic [LHT_IDX_BITS-1:0] w_pidx;
    logic [LHT_IDX_BITS-1:0] w_uidx;
    logic [HIST_BITS-1:0]    w_upd_hist;
    logic [HIST_BITS-1:0]    w_upd_hist_next;
    logic [CTR_BITS-1:0]     w_upd_ctr;
    logic [CTR_BITS-1:0]     w_upd_ctr_next;
    logic [HIST_BITS-1:0]    w_pred_hist;
    logic [CTR_BITS-1:0]     w_pred_ctr;
    logic                    w_ready;
    logic                    w_unused;

    assign w_ready         = (r_state == READY);
    assign w_pidx          = pred_pc[LHT_IDX_BITS+1:2];
    assign w_uidx          = upd_pc[LHT_IDX_BITS+1:2];
    assign w_upd_hist      = r_lht[w_uidx];
    assign w_upd_hist_next = {w_upd_hist[HIST_BITS-2:0], upd_taken};
    assign w_upd_ctr       = r_pht[w_upd_hist];
    assign w_upd_ctr_next  = upd_taken ? ((w_upd_ctr == CTR_MAX) ? w_upd_ctr : w_upd_ctr + 1'b1)
                                       : ((w_upd_ctr == '0) ? w_upd_ctr : w_upd_ctr - 1'b1);

`ifdef LP_BYPASS_EN
    // An update in the same cycle overrides the stored history and counter it is about to rewrite.
    assign w_pred_hist = (upd_valid && w_uidx == w_pidx) ? w_upd_hist_next : r_lht[w_pidx];
    assign w_pred_ctr  = (upd_valid && w_upd_hist == w_pred_hist) ? w_upd_ctr_next : r_pht[w_pred_hist];
`else
    assign w_pred_hist = r_lht[w_pidx];
    assign w_pred_ctr  = r_pht[w_pred_hist];
`endif

    assign w_unused = ^{pred_pc[PC_BITS-1:LHT_IDX_BITS+2], pred_pc[1:0],
                        upd_pc[PC_BITS-1:LHT_IDX_BITS+2], upd_pc[1:0]};

    // Init sweep: one index per cycle over the larger table, then serve requests.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
            r_idx   <= '0;
        end else if (r_state == INIT) begin
            r_idx <= r_idx + 1'b1;
            if (&r_idx)
                r_state <= READY;
        end
    end

    // Registered prediction response; direction and history hold between responses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_hist  <= '0;
        end else begin
            r_resp_valid <= pred_valid && w_ready;
            if (pred_valid && w_ready) begin
                r_pred_taken <= w_pred_ctr[CTR_BITS-1];
                r_pred_hist  <= w_pred_hist;
            end
        end
    end

    // Table writes: clear during the sweep, then history shift and counter step on each update.
    always_ff @(posedge clock) begin
        if (r_state == INIT) begin
            if ((r_idx >> LHT_IDX_BITS) == '0)
                r_lht[r_idx[LHT_IDX_BITS-1:0]] <= '0;
            if ((r_idx >> HIST_BITS) == '0)
                r_pht[r_idx[HIST_BITS-1:0]] <= CTR_INIT;
        end else if (upd_valid) begin
            r_lht[w_uidx]      <= w_upd_hist_next;
            r_pht[w_upd_hist]  <= w_upd_ctr_next;
        end
    end

    assign ready           = w_ready;
    assign pred_resp_valid = r_resp_valid;
    assign pred_taken      = r_pred_taken;
    assign pred_hist       = r_pred_hist;
endmodule

// File: tb/tb_local_predictor_2lvl.sv
// tb_local_predictor_2lvl: randomized and directed checks of local_predictor_2lvl against a table-level reference model.
module tb_local_predictor_2lvl;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        ready;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_resp_valid;
    logic        pred_taken;
    logic [9:0]  pred_hist;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;

    int n_total = 0;
    int n_bad   = 0;
    int m_lht [64];
    int m_pht [1024];
    int exp_hist;
    int exp_taken;

    local_predictor_2lvl dut (
        .clock(clock), .reset_n(reset_n), .ready(ready),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken), .pred_hist(pred_hist),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic int sat_step(input int c, input logic t);
        if (t) return (c + 1 > 7) ? 7 : c + 1;
        return (c - 1 < 0) ? 0 : c - 1;
    endfunction

    task automatic do_init(input int abort_at);
        int  cnt;
        bit  seen;
        @(posedge clock); #1;
        reset_n = 1'b0;
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_resp", pred_resp_valid, 0);
        check("rst_taken", pred_taken, 0);
        check("rst_hist", pred_hist, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        if (abort_at > 0) begin
            repeat (abort_at) begin @(posedge clock); #1; end
            check("mid_ready", ready, 0);
            reset_n = 1'b0;
            #1 check("mid_rst_ready", ready, 0);
            @(posedge clock);
            #1 reset_n = 1'b1;
        end
        cnt  = 0;
        seen = 0;
        while (!ready && cnt < 2000) begin
            pred_valid = 1'($urandom);
            pred_pc    = $urandom;
            upd_valid  = 1'($urandom);
            upd_pc     = $urandom;
            upd_taken  = 1'($urandom);
            @(posedge clock); #1;
            cnt++;
            if (pred_resp_valid) seen = 1;
        end
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        check("init_cycles", cnt, 1024);
        check("init_resp", seen, 0);
        foreach (m_lht[i]) m_lht[i] = 0;
        foreach (m_pht[i]) m_pht[i] = 3;
        exp_hist  = 0;
        exp_taken = 0;
    endtask

    task automatic step(input logic pv, input logic [31:0] ppc, input logic uv,
                        input logic [31:0] upc, input logic ut);
        int pi, ui, h, uh, c;
        pred_valid = pv;
        pred_pc    = ppc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        pi = int'(ppc >> 2) % 64;
        ui = int'(upc >> 2) % 64;
        uh = m_lht[ui];
        h  = m_lht[pi];
`ifdef LP_BYPASS_EN
        if (uv && ui == pi) h = (uh * 2 + int'(ut)) % 1024;
`endif
        c = m_pht[h];
`ifdef LP_BYPASS_EN
        if (uv && uh == h) c = sat_step(c, ut);
`endif
        if (pv) begin
            exp_hist  = h;
            exp_taken = (c >= 4) ? 1 : 0;
        end
        if (uv) begin
            m_pht[uh] = sat_step(m_pht[uh], ut);
            m_lht[ui] = (uh * 2 + int'(ut)) % 1024;
        end
        @(posedge clock); #1;
        check("resp_valid", pred_resp_valid, 32'(pv));
        check("pred_hist", pred_hist, exp_hist);
        check("pred_taken", pred_taken, exp_taken);
    endtask

    initial begin
        reset_n    = 1'b0;
        pred_valid = 1'b0;
        pred_pc    = '0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        do_init(0);
        repeat (5) step(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
        check("post_init_hist", pred_hist, 0);
        check("post_init_taken", pred_taken, 0);
        step(1'b1, 32'h14, 1'b1, 32'h14, 1'b1);
`ifdef LP_BYPASS_EN
        check("same_cycle_hist", pred_hist, 1);
`else
        check("same_cycle_hist", pred_hist, 0);
`endif
        do_init(500);
        repeat (3) step(1'b0, 32'h0, 1'b1, 32'h14, 1'b1);
        step(1'b1, 32'h14, 1'b0, 32'h0, 1'b0);
        check("hist_after_3", pred_hist, 7);
        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        check("pht0_taken", pred_taken, 1);
        step(1'b0, 32'h0, 1'b1, 32'h18, 1'b1);
        step(1'b1, 32'h18, 1'b0, 32'h0, 1'b0);
        check("pht1_taken", pred_taken, 1);
        for (int p = 10; p < 19; p++)
            repeat (10) step(1'b0, 32'h0, 1'b1, 32'(p * 4), 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1, 32'(10 * 4), 1'b1);
        step(1'b1, 32'(10 * 4), 1'b0, 32'h0, 1'b0);
        check("sat_hi_hist", pred_hist, 32'h3ff);
        check("sat_hi_taken", pred_taken, 1);
        for (int p = 11; p < 19; p++)
            step(1'b0, 32'h0, 1'b1, 32'(p * 4), 1'b0);
        step(1'b1, 32'(10 * 4), 1'b0, 32'h0, 1'b0);
        check("sat_lo_taken", pred_taken, 0);
        repeat (10) step(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (3000)
            step(1'($urandom), ($urandom & 32'hFFFF_FF03) | (($urandom % 4) << 2),
                 1'($urandom), ($urandom & 32'hFFFF_FF03) | (($urandom % 4) << 2),
                 1'($urandom));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
